// File: rtl/adder_seq_ctrl.sv
// rtl/adder_seq_ctrl.sv - multi-cycle wide add/sub sequencer over one WIDTH-bit adder slice
// Processes one chunk per RUN cycle, LSB chunk first, with carry kept between chunks.
module adder_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     sub,
  input  logic [WIDTH*WORDS-1:0]   in_a,
  input  logic [WIDTH*WORDS-1:0]   in_b,
  output logic                     ready,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH*WORDS-1:0]   out,
  output logic                     cout,
  output logic                     overflow
);

  localparam int N     = WIDTH * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [N-1:0]       a_reg;
  logic [N-1:0]       b_reg;
  logic               sub_reg;
  logic               carry;
  logic [IDX_W-1:0]   idx;

  logic [WIDTH-1:0]   chunk_a;
  logic [WIDTH-1:0]   chunk_b_eff;
  logic [WIDTH:0]     slice_sum;
  logic               last_chunk;
  logic               msb_cin;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_chunk) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Subtraction is a + ~b + 1: the +1 comes from seeding carry with sub at accept.
  always_comb begin
    chunk_a     = a_reg[idx*WIDTH +: WIDTH];
    chunk_b_eff = b_reg[idx*WIDTH +: WIDTH] ^ {WIDTH{sub_reg}};
    slice_sum   = {1'b0, chunk_a} + {1'b0, chunk_b_eff} + {{WIDTH{1'b0}}, carry};
    last_chunk  = (idx == IDX_W'(WORDS - 1));
    msb_cin     = chunk_a[WIDTH-1] ^ chunk_b_eff[WIDTH-1] ^ slice_sum[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      sub_reg  <= 1'b0;
      carry    <= 1'b0;
      idx      <= '0;
      out      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= in_a;
            b_reg   <= in_b;
            sub_reg <= sub;
            carry   <= sub;
            idx     <= '0;
            out     <= '0;
          end
        end
        RUN: begin
          out[idx*WIDTH +: WIDTH] <= slice_sum[WIDTH-1:0];
          carry                   <= slice_sum[WIDTH];
          if (last_chunk) begin
            idx      <= '0;
            cout     <= slice_sum[WIDTH];
            overflow <= msb_cin ^ slice_sum[WIDTH];
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
Multi-cycle sequencer that performs wide add/subtract by driving one WIDTH-bit adder slice over WORDS cycles, LSB chunk first, propagating carry between chunks. It lets the ALU support WIDTH*WORDS-bit operands without a full-width adder. A start/done handshake sits toward the issuing control logic. Result, carry-out and signed overflow are registered outputs.

Parameters:
WIDTH, 4, bits per adder slice (chunk width)
WORDS, 4, number of chunks; total operand width N = WIDTH*WORDS (WORDS >= 1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  request; accepted only when ready=1
sub  input  1  0 = a+b, 1 = a-b; sampled with start
in_a  input  N  operand A; sampled with start
in_b  input  N  operand B; sampled with start
ready  output  1  high in IDLE only
busy  output  1  high in RUN only
done  output  1  one-cycle pulse when result is valid
out  output  N  result register
cout  output  1  carry out of the MSB chunk; for sub, 1 = no borrow
overflow  output  1  two's-complement overflow of the full N-bit operation

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, chunk index=0, out=0, cout=0, overflow=0, done=0, busy=0, ready=1. Reset wins over all other inputs and aborts RUN/DONE mid-operation; the partial result is discarded (out=0).
- States: IDLE, RUN, DONE.
- IDLE: ready=1. On start=1: latch in_a, in_b and sub; set idx=0; set carry=sub; set out=0; go to RUN. start=0: hold state, outputs unchanged. The previous result stays visible.
- RUN (busy=1, ready=0), once per cycle for chunk k=idx:
  - b_eff = in_b chunk k XOR {WIDTH{sub}}.
  - {c, s} = a chunk k + b_eff + carry, computed at WIDTH+1 bits.
  - Write s into out[k*WIDTH +: WIDTH]; set carry=c; increment idx.
  - When k = WORDS-1: cout=c; overflow = (carry into bit N-1) XOR c; go to DONE.
- DONE: done=1 for exactly one cycle; out, cout and overflow are final. Next state is IDLE.
- Latency: start sampled at edge T gives done=1 during cycle T+WORDS+1. Back-to-back issue: start is accepted at edge T+WORDS+2 at the earliest.
- start while RUN or DONE is ignored; no queueing. Latched operands are unaffected by input changes after acceptance.
- out, cout and overflow change only in RUN (chunk-wise) and at reset. They hold their value in DONE and IDLE until the next accepted start clears out.
- Arithmetic is modulo 2^N; no saturation. The carry chain wraps nothing between operations: carry re-initialises from sub at each accept.
- WORDS=1 degenerates to a single RUN cycle; all rules above still hold.

Test Plan (WIDTH=4, WORDS=4, N=16):
1. Reset, then start, sub=0, a=0x0003, b=0x0004 -> busy for 4 cycles; done pulses at T+5; out=0x0007, cout=0, overflow=0; ready returns high the following cycle.
2. Carry ripple through all chunks: a=0xFFFF, b=0x0001, add -> out=0x0000, cout=1, overflow=0. Then a=0x7FFF, b=0x0001, add -> out=0x8000, cout=0, overflow=1.
3. Subtract: a=0x0003, b=0x0005, sub=1 -> out=0xFFFE, cout=0, overflow=0. Then a=0x8000, b=0x0001, sub=1 -> out=0x7FFF, cout=1, overflow=1.
4. Re-issue start with new operands during RUN and again during the DONE cycle -> both ignored; the first operation completes with its original result. A start issued the cycle after done (ready=1) is accepted.
5. Assert rst for one cycle at the second RUN cycle of 0x1234+0x1111 -> next cycle IDLE, ready=1, out=0, done never pulses. A fresh 0x1234+0x1111 then yields 0x2345.
6. Hold start=1 continuously with fixed operands 0x00FF+0x0001 -> an operation completes every 6 cycles; out=0x0100 at each done pulse; done is never high two cycles in a row.
